// File: rtl/shifter_pkg.sv
// Purpose: shared constants and FSM state type for the shifter round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shifter_pkg;

    localparam int DATA_W   = 8;   // operand/result width, fixed by the shifter datapath
    localparam int SHIFT_W  = 3;   // rotate amount width, fixed by the shifter datapath
    localparam int NREQ_DEF = 4;   // default number of requesters

    // EMPTY: no result held; FULL: result register holds a valid result.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/shifter_rr_arbiter_barrel_shifter.sv
// Purpose: 8-bit mux-based rotate-left by 0..7 (log-depth, one mux stage per shift bit).
// Latency: purely combinational.
// Backpressure: none; no state.
// Ports:
//   datain  - operand to rotate
//   shift   - rotate-left amount
//   dataout - datain rotated left by shift
module BarrelShifter
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0]  datain,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  dataout
);

    logic [DATA_W-1:0] stage1;
    logic [DATA_W-1:0] stage2;

    // Stages rotate by 1, 2 and 4 respectively.
    assign stage1  = shift[0] ? {datain[DATA_W-2:0], datain[DATA_W-1]}   : datain;
    assign stage2  = shift[1] ? {stage1[DATA_W-3:0], stage1[DATA_W-1 -: 2]} : stage1;
    assign dataout = shift[2] ? {stage2[DATA_W-5:0], stage2[DATA_W-1 -: 4]} : stage2;

endmodule

// File: rtl/shifter_rr_arbiter.sv
// Purpose: round-robin sharing of one barrel shifter among NREQ valid/ready requesters.
// Latency: result is registered; visible the cycle after the request is accepted.
// Backpressure: out_ready low with a held result blocks all req_ready; drain+accept in one cycle.
// Ports:
//   clk, rst_n            - clock; synchronous active-low reset
//   req_valid/req_ready   - per-requester handshake (req_ready one-hot or zero)
//   req_data/req_shift    - packed per-requester operand and rotate amount
//   out_valid/out_ready   - result handshake
//   out_data/out_id       - rotated operand and index of the requester that produced it
//   busy                  - result stage occupied (equals out_valid)
module shifter_rr_arbiter #(
    parameter int NREQ    = shifter_pkg::NREQ_DEF,
    parameter int DATA_W  = shifter_pkg::DATA_W,
    parameter int SHIFT_W = shifter_pkg::SHIFT_W,
    parameter int ID_W    = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    input  logic [NREQ*SHIFT_W-1:0] req_shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [ID_W-1:0]         out_id,
    output logic                    busy
);

    import shifter_pkg::*;

    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam int            PW     = ID_W + 1;
    localparam logic [PW-1:0] NREQ_P = PW'(NREQ);

    state_e             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [DATA_W-1:0]  out_data_q;
    logic [ID_W-1:0]    out_id_q;

    logic               grant_vld;
    logic [ID_W-1:0]    grant_idx;
    logic               can_accept;
    logic               accept;
    logic [DATA_W-1:0]  sel_data;
    logic [SHIFT_W-1:0] sel_shift;
    logic [DATA_W-1:0]  shifted;

    // Priority search starting at rr_ptr, wrapping modulo NREQ; first valid wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + PW'(k);
            if (idx >= NREQ_P) begin
                idx = idx - NREQ_P;
            end
            if (!grant_vld && req_valid[idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx[ID_W-1:0];
            end
        end
    end

    assign can_accept = (state_q == EMPTY) || out_ready;
    // Reset gates acceptance combinationally so no requester sees a handshake while held in reset.
    assign accept     = rst_n && grant_vld && can_accept;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign rr_ptr_d = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);

    assign sel_data  = req_data[grant_idx * DATA_W +: DATA_W];
    assign sel_shift = req_shift[grant_idx * SHIFT_W +: SHIFT_W];

    BarrelShifter u_shifter (
        .datain  (sel_data),
        .shift   (sel_shift),
        .dataout (shifted)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
        end else if (accept) begin
            // Covers both EMPTY->FULL and the back-to-back drain+accept case.
            state_q    <= FULL;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= shifted;
            out_id_q   <= grant_idx;
        end else if (state_q == FULL && out_ready) begin
            state_q    <= EMPTY;
        end
    end

    assign out_valid = (state_q == FULL);
    assign busy      = out_valid;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule
